// File: rtl/colour_conversion_controller.sv
// Sequencing FSM for colour_conversion_datapath: YUV word fetch, six colour steps, three RGB writes per pixel pair.
// Optional stall input (mem_busy) is compiled in when COLOUR_CTRL_STALL_EN is defined.
module colour_conversion_controller #(
    parameter int unsigned NUM_PAIRS = 38400,
    parameter logic [17:0] Y_BASE    = 18'd0,
    parameter logic [17:0] U_BASE    = 18'd38400,
    parameter logic [17:0] V_BASE    = 18'd76800,
    parameter logic [17:0] RGB_BASE  = 18'd115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef COLOUR_CTRL_STALL_EN
    input  logic        mem_busy,
`endif
    output logic [17:0] SRAM_addr,
    output logic        W_en,
    output logic        Yen_odd,
    output logic        Yen_even,
    output logic        Uen_odd,
    output logic        Uen_even,
    output logic        Ven_odd,
    output logic        Ven_even,
    output logic        Smux1,
    output logic [1:0]  Smux2,
    output logic        Temp_en,
    output logic        Cen,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_RD_Y = 4'd1,
        S_RD_U = 4'd2,
        S_RD_V = 4'd3,
        S_LD_V = 4'd4,
        S_E_R  = 4'd5,
        S_E_G  = 4'd6,
        S_E_B  = 4'd7,
        S_O_R  = 4'd8,
        S_O_G  = 4'd9,
        S_O_B  = 4'd10,
        S_DONE = 4'd11
    } state_t;

    typedef struct packed {
        logic [17:0] addr;
        logic        w_en;
        logic        yen;
        logic        uen;
        logic        ven;
        logic        smux1;
        logic [1:0]  smux2;
        logic        temp_en;
        logic        cen;
        logic        busy;
        logic        done;
    } ctrl_out_t;

    localparam logic [16:0] LAST_PAIR = 17'(NUM_PAIRS - 1);

    state_t      state_reg;
    state_t      state_next;
    logic [16:0] p_reg;
    logic [16:0] p_next;
    ctrl_out_t   out_reg;
    ctrl_out_t   out_next;
    logic        stall;

`ifdef COLOUR_CTRL_STALL_EN
    // DONE and IDLE are never frozen so a frame can always complete and restart.
    assign stall = mem_busy && (state_reg != S_IDLE) && (state_reg != S_DONE);
`else
    assign stall = 1'b0;
`endif

    // Output decode for a given state and pair index; applied to the next state so outputs are registered.
    function automatic ctrl_out_t decode(input state_t s, input logic [16:0] p);
        ctrl_out_t   o;
        logic [17:0] p_ext;
        logic [17:0] rgb_addr;
        p_ext    = {1'b0, p};
        rgb_addr = RGB_BASE + (p_ext << 1) + p_ext;
        o        = '0;
        o.busy   = (s != S_IDLE);
        case (s)
            S_IDLE: o.busy = 1'b0;
            S_RD_Y: o.addr = Y_BASE + p_ext;
            S_RD_U: begin
                o.addr = U_BASE + p_ext;
                o.yen  = 1'b1;
            end
            S_RD_V: begin
                o.addr = V_BASE + p_ext;
                o.uen  = 1'b1;
            end
            S_LD_V: o.ven = 1'b1;
            S_E_R: begin
                o.smux1   = 1'b1;
                o.smux2   = 2'd0;
                o.temp_en = 1'b1;
            end
            S_E_G: begin
                o.smux1 = 1'b1;
                o.smux2 = 2'd1;
                o.w_en  = 1'b1;
                o.addr  = rgb_addr;
            end
            S_E_B: begin
                o.smux1   = 1'b1;
                o.smux2   = 2'd2;
                o.temp_en = 1'b1;
            end
            S_O_R: begin
                o.smux1 = 1'b0;
                o.smux2 = 2'd0;
                o.w_en  = 1'b1;
                o.addr  = rgb_addr + 18'd1;
            end
            S_O_G: begin
                o.smux1   = 1'b0;
                o.smux2   = 2'd1;
                o.temp_en = 1'b1;
            end
            S_O_B: begin
                o.smux1 = 1'b0;
                o.smux2 = 2'd2;
                o.w_en  = 1'b1;
                o.cen   = 1'b1;
                o.addr  = rgb_addr + 18'd2;
            end
            S_DONE: o.done = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        state_next = state_reg;
        p_next     = p_reg;
        if (!stall) begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_next = S_RD_Y;
                        p_next     = '0;
                    end
                end
                S_RD_Y: state_next = S_RD_U;
                S_RD_U: state_next = S_RD_V;
                S_RD_V: state_next = S_LD_V;
                S_LD_V: state_next = S_E_R;
                S_E_R:  state_next = S_E_G;
                S_E_G:  state_next = S_E_B;
                S_E_B:  state_next = S_O_R;
                S_O_R:  state_next = S_O_G;
                S_O_G:  state_next = S_O_B;
                S_O_B: begin
                    if (p_reg == LAST_PAIR) begin
                        state_next = S_DONE;
                    end else begin
                        p_next     = p_reg + 17'd1;
                        state_next = S_RD_Y;
                    end
                end
                S_DONE: state_next = S_IDLE;
                default: begin
                    state_next = S_IDLE;
                    p_next     = '0;
                end
            endcase
        end
        // An illegal matrix-row select means the output register was corrupted; abandon the frame.
        if (out_reg.smux2 == 2'd3) begin
            state_next = S_IDLE;
            p_next     = '0;
        end
        out_next = decode(state_next, p_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            p_reg     <= '0;
            out_reg   <= '0;
        end else begin
            state_reg <= state_next;
            p_reg     <= p_next;
            out_reg   <= out_next;
        end
    end

    // Strobes are masked while stalled; the address and mux selects simply hold.
    assign SRAM_addr = out_reg.addr;
    assign W_en      = out_reg.w_en    & ~stall;
    assign Yen_odd   = out_reg.yen     & ~stall;
    assign Yen_even  = out_reg.yen     & ~stall;
    assign Uen_odd   = out_reg.uen     & ~stall;
    assign Uen_even  = out_reg.uen     & ~stall;
    assign Ven_odd   = out_reg.ven     & ~stall;
    assign Ven_even  = out_reg.ven     & ~stall;
    assign Smux1     = out_reg.smux1;
    assign Smux2     = out_reg.smux2;
    assign Temp_en   = out_reg.temp_en & ~stall;
    assign Cen       = out_reg.cen     & ~stall;
    assign busy      = out_reg.busy;
    assign done      = out_reg.done;

endmodule

// File: tb/tb_colour_conversion_controller.sv
// Scoreboard bench for colour_conversion_controller with a three-pair frame.
module tb_colour_conversion_controller;

    localparam int          NP = 3;
    localparam logic [17:0] YB = 18'd0;
    localparam logic [17:0] UB = 18'd38400;
    localparam logic [17:0] VB = 18'd76800;
    localparam logic [17:0] RB = 18'd115200;

    localparam logic [8:0] M_Y    = 9'b0_0000_0011;
    localparam logic [8:0] M_U    = 9'b0_0000_1100;
    localparam logic [8:0] M_V    = 9'b0_0011_0000;
    localparam logic [8:0] M_T    = 9'b0_0100_0000;
    localparam logic [8:0] M_W    = 9'b0_1000_0000;
    localparam logic [8:0] M_DONE = 9'b1_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [17:0] SRAM_addr;
    logic        W_en, Yen_odd, Yen_even, Uen_odd, Uen_even, Ven_odd, Ven_even;
    logic        Smux1, Temp_en, Cen, busy, done;
    logic [1:0]  Smux2;
`ifdef COLOUR_CTRL_STALL_EN
    logic        mem_busy = 1'b0;
`endif

    colour_conversion_controller #(.NUM_PAIRS(NP)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef COLOUR_CTRL_STALL_EN
        .mem_busy(mem_busy),
`endif
        .SRAM_addr(SRAM_addr), .W_en(W_en),
        .Yen_odd(Yen_odd), .Yen_even(Yen_even),
        .Uen_odd(Uen_odd), .Uen_even(Uen_even),
        .Ven_odd(Ven_odd), .Ven_even(Ven_even),
        .Smux1(Smux1), .Smux2(Smux2), .Temp_en(Temp_en), .Cen(Cen),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // One observable event: strobe set, address (load events report the address of the previous cycle), selects, Cen.
    typedef struct packed {
        logic [8:0]  strobes;
        logic [17:0] addr;
        logic        smux1;
        logic [1:0]  smux2;
        logic        cen;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;

    function automatic ev_t mk(input logic [8:0] s, input logic [17:0] a, input logic m1,
                               input logic [1:0] m2, input logic c);
        ev_t e;
        e.strobes = s; e.addr = a; e.smux1 = m1; e.smux2 = m2; e.cen = c;
        return e;
    endfunction

    // Reference: for every pair read Y,U,V then three colour steps interleaved with three RGB writes.
    task automatic push_frame();
        for (int p = 0; p < NP; p++) begin
            logic [17:0] pp;
            logic [17:0] rgb;
            pp  = 18'(p);
            rgb = RB + 18'(3 * p);
            sb.push_back(mk(M_Y, YB + pp, 1'b0, 2'd0, 1'b0));
            sb.push_back(mk(M_U, UB + pp, 1'b0, 2'd0, 1'b0));
            sb.push_back(mk(M_V, VB + pp, 1'b0, 2'd0, 1'b0));
            sb.push_back(mk(M_T, 18'd0,   1'b1, 2'd0, 1'b0));
            sb.push_back(mk(M_W, rgb,     1'b1, 2'd1, 1'b0));
            sb.push_back(mk(M_T, 18'd0,   1'b1, 2'd2, 1'b0));
            sb.push_back(mk(M_W, rgb + 18'd1, 1'b0, 2'd0, 1'b0));
            sb.push_back(mk(M_T, 18'd0,   1'b0, 2'd1, 1'b0));
            sb.push_back(mk(M_W, rgb + 18'd2, 1'b0, 2'd2, 1'b1));
        end
        sb.push_back(mk(M_DONE, 18'd0, 1'b0, 2'd0, 1'b0));
    endtask

    task automatic check_zero(input string name);
        logic [31:0] v;
        v = {SRAM_addr, W_en, Yen_odd, Yen_even, Uen_odd, Uen_even, Ven_odd, Ven_even,
             Smux1, Smux2, Temp_en, Cen, busy, done};
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL %s outputs=%h required=0", name, v);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b required=%b", name, got, want);
        end
    endtask

    // Waits at negedges for done; optionally toggles start at random while busy (must be ignored).
    task automatic wait_done(input bit noise);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10 * NP + 20) begin
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (noise) start = busy && ($urandom_range(0, 3) == 0);
                @(negedge clk);
                n++;
            end
        end
        if (noise) start = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout waited=%0d cycles required=done pulse", n);
        end
    endtask

    // Monitor: compares every strobe cycle against the scoreboard, and frame length / idle address.
    initial begin
        logic [17:0] prev_addr;
        logic [8:0]  s;
        int          run;
        ev_t         obs;
        ev_t         want;
        prev_addr = '0;
        run       = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_addr = '0;
                run       = 0;
                continue;
            end
            s = {done, W_en, Temp_en, Ven_odd, Ven_even, Uen_odd, Uen_even, Yen_odd, Yen_even};
            if (s != 9'd0 || Cen) begin
                obs = mk(s, (s[5:0] != 6'd0) ? prev_addr : SRAM_addr, Smux1, Smux2, Cen);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event got=%h required=none", obs);
                end else begin
                    want = sb.pop_front();
                    if (obs !== want) begin
                        errors++;
                        $display("FAIL event got=%h required=%h", obs, want);
                    end else begin
                        $display("txn strobes=%b addr=%0d smux1=%b smux2=%0d cen=%b",
                                 obs.strobes, obs.addr, obs.smux1, obs.smux2, obs.cen);
                    end
                end
            end
            if (busy) begin
                run++;
            end else begin
                if (run > 0) begin
                    checks++;
                    if (run != 10 * NP + 1) begin
                        errors++;
                        $display("FAIL frame_length got=%0d required=%0d", run, 10 * NP + 1);
                    end
                end
                run = 0;
                checks++;
                if (SRAM_addr !== 18'd0) begin
                    errors++;
                    $display("FAIL idle_addr got=%0d required=0", SRAM_addr);
                end
            end
            prev_addr = SRAM_addr;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle_after_reset");

        // Randomly spaced frames with spurious start pulses while busy.
        for (int f = 0; f < 5; f++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            push_frame();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_done(1'b1);
            @(negedge clk);
        end

        // start held high: DONE, IDLE, RD_Y back to back.
        push_frame();
        push_frame();
        start = 1'b1;
        @(negedge clk);
        wait_done(1'b0);
        @(negedge clk);
        check_bit("held_start_idle_gap", busy, 1'b0);
        @(negedge clk);
        check_bit("held_start_restart", busy, 1'b1);
        start = 1'b0;
        wait_done(1'b0);
        @(negedge clk);

        // Asynchronous reset in the first E_G write cycle.
        push_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (W_en && Smux1 && Smux2 == 2'd1) found = 1'b1;
            else @(negedge clk);
        end
        check_bit("reach_e_g", found, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset_mid_frame");
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_zero("idle_after_mid_reset");
        end

        // A full frame after the abort must start again from pair 0.
        push_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b1);
        repeat (3) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_events got=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
